fetch_realign_buffer: RTL
=========================

FETCH_REALIGN_BUFFER -- requirements
Module: fetch_realign_buffer

Interface
REQ-001 The block SHALL have parameter CExtEn, default cva6_config_pkg::CVA6ConfigCExtEn (1), meaning 16-bit compressed instructions are recognised.
REQ-002 The block SHALL have parameter Xlen, default cva6_config_pkg::CVA6ConfigXlen (64), meaning the width of every address/PC.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discards all held state.
REQ-006 The block SHALL have ports fetch_valid_i (input, 1), fetch_ready_o (output, 1), fetch_data_i (input, 32), fetch_addr_i (input, Xlen; bit 1 = start halfword, bit 0 ignored) and fetch_fault_i (input, 1).
REQ-007 The block SHALL have ports instr_valid_o (output, 1), instr_ready_i (input, 1), instr_o (output, 32), instr_pc_o (output, Xlen), instr_compressed_o (output, 1) and instr_fault_o (output, 1).

Function
REQ-008 Any word SHALL transfer when fetch_valid_i & fetch_ready_o, and any instruction SHALL transfer when instr_valid_o & instr_ready_i.
REQ-009 Held state SHALL be: word register (data, word-aligned PC, fault, valid), halfword pointer ptr (0/1), carry register (16-bit lower half, its PC, valid).
REQ-010 The FSM SHALL have three states: EMPTY (no word, no carry), WORD (word held, no carry) and CARRY (carry held, with or without word).
REQ-011 An accepted word SHALL load ptr from fetch_addr_i[1] when the state is EMPTY; a word accepted in CARRY SHALL load ptr = 0.
REQ-012 In CARRY with a word held, the output SHALL be {hw[ptr], carry}, compressed = 0, pc = carry PC, after which the word SHALL advance one halfword and the carry SHALL clear.
REQ-013 In WORD, when CExtEn = 1 and hw[ptr][1:0] != 2'b11, the output SHALL be the zero-extended {16'b0, hw[ptr]}, compressed = 1, pc = word PC + 2*ptr, after which the word SHALL advance one halfword.
REQ-014 In WORD, for a 32-bit instruction with ptr = 0, the output SHALL be the full word and the word SHALL be consumed.
REQ-015 In WORD, for a 32-bit instruction with ptr = 1, hw[1] SHALL move to carry (PC = word PC + 2), the word SHALL be consumed, no output SHALL be produced, and the state SHALL go to CARRY.
REQ-016 When CExtEn = 0, every halfword pair SHALL be treated as 32-bit, ptr SHALL always be 0, and CARRY SHALL be unreachable.
REQ-017 A word is exhausted when it advances past ptr = 1; on exhaustion the state SHALL return to EMPTY unless a new word is accepted in the same cycle.
REQ-018 fetch_ready_o SHALL equal !word_valid | (word exhausted this cycle), allowing back-to-back words with zero bubble.
REQ-019 fetch_ready_o SHALL be 0 while flush_i is high.
REQ-020 A word held with fault = 1 SHALL emit exactly one instruction, fault = 1, data = 0, pc = carry PC if a carry exists else word PC + 2*ptr; that emission SHALL consume both word and carry.
REQ-021 instr_valid_o SHALL be combinational from registered state and SHALL be 0 in EMPTY, in CARRY without a word, and while flush_i is high.
REQ-022 While instr_valid_o = 1 and instr_ready_i = 0, all instr_* outputs SHALL remain stable.
REQ-023 Latency SHALL be one cycle: a word accepted at edge N SHALL be presentable at cycle N+1; throughput SHALL be one instruction per cycle.
REQ-024 flush_i SHALL clear word valid, carry valid and ptr at the next edge, with priority over any simultaneous accept or emit, and no transfer SHALL be counted in that cycle.
REQ-025 Each PC addition SHALL be computed in Xlen bits and wrap modulo 2^Xlen.

Reset
REQ-026 Asserting rst_i SHALL immediately clear all valid bits, ptr and carry, set state to EMPTY and drive instr_valid_o = 0 and fetch_ready_o = 1.
REQ-027 All data/PC registers SHALL reset to 0.
REQ-028 Reset mid-instruction SHALL discard a pending carry with no output.

Structure
REQ-029 The state enum and the fetch-entry / instruction-entry struct typedefs SHALL live in a shared package alongside cva6_config_pkg.
REQ-030 The design SHALL include one sub-module, rvc_len_detect (combinational halfword -> is_compressed, gated by CExtEn); all remaining logic SHALL be one module.

Verification
REQ-031 The bench SHALL cover: word 0x00010001 @0x1000, ready=1 -> two compressed instrs 0x0001 @0x1000, 0x0001 @0x1002 on consecutive cycles.
REQ-032 The bench SHALL cover: word 0x00000013 @0x2000 -> one 32-bit instr 0x00000013 @0x2000, compressed = 0.
REQ-033 The bench SHALL cover: 0x00130001 @0x3000, then 0x12340000 @0x3004 -> 0x0001 @0x3000, then 0x00000013 @0x3002, then 0x1234 @0x3006.
REQ-034 The bench SHALL cover: word @0x4002 whose hw1 = 0x0013, then a fault word -> one output, fault = 1, pc = 0x4002, then state EMPTY.
REQ-035 The bench SHALL cover: a carry pending plus flush_i = 1 with fetch_valid_i = 1 -> no output, nothing accepted, next word at @0x5000 emitted from pc 0x5000.
REQ-036 The bench SHALL cover: instr_ready_i held low for 3 cycles -> outputs stable, fetch_ready_o = 0, then no instruction lost or duplicated.

Source files
------------

// File: rtl/cva6_config_pkg.sv
// Core-wide configuration knobs shared by the frontend blocks.
// Values here set the defaults of every parameterised unit.
package cva6_config_pkg;
   localparam bit          CVA6ConfigCExtEn = 1'b1;
   localparam int unsigned CVA6ConfigXlen   = 64;
endpackage

// File: rtl/fetch_realign_buffer_pkg.sv
// Shared types for the fetch realign buffer: FSM states,
// fetch/instruction bundles and halfword helpers.
package fetch_realign_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WORD  = 2'd1,
      CARRY = 2'd2
   } frb_state_e;

   typedef struct packed {
      logic [31:0] data;
      logic        fault;
   } fetch_entry_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        compressed;
      logic        fault;
   } instr_entry_t;

   localparam logic [1:0] RVC_OP_FULL = 2'b11;

   function automatic logic [15:0] hw_select(
      input logic [31:0] w,
      input logic        sel
   );
      return sel ? w[31:16] : w[15:0];
   endfunction

endpackage

// File: rtl/fetch_realign_buffer_rvc.sv
// Instruction length detect: a halfword starts a 16-bit
// instruction when its low opcode bits are not 2'b11.
module rvc_len_detect
   import fetch_realign_buffer_pkg::*;
#(
   parameter bit CExtEn = 1'b1
) (
   input  logic [15:0] hw_i,
   output logic        is_compressed_o
);
   logic unused_hi;

   assign unused_hi       = ^hw_i[15:2];
   assign is_compressed_o = CExtEn && (hw_i[1:0] != RVC_OP_FULL);
endmodule

// File: rtl/fetch_realign_buffer.sv
// Realigns 32-bit fetch words into 16/32-bit instructions,
// carrying a split lower half across word boundaries.
module fetch_realign_buffer
   import fetch_realign_buffer_pkg::*;
#(
   parameter bit          CExtEn = cva6_config_pkg::CVA6ConfigCExtEn,
   parameter int unsigned Xlen   = cva6_config_pkg::CVA6ConfigXlen
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            fetch_valid_i,
   output logic            fetch_ready_o,
   input  logic [31:0]     fetch_data_i,
   input  logic [Xlen-1:0] fetch_addr_i,
   input  logic            fetch_fault_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [31:0]     instr_o,
   output logic [Xlen-1:0] instr_pc_o,
   output logic            instr_compressed_o,
   output logic            instr_fault_o
);
   typedef logic [Xlen-1:0] pc_t;

   frb_state_e   state_q, state_d;
   fetch_entry_t word_q, word_d;
   pc_t          word_pc_q, word_pc_d;
   logic         word_valid_q, word_valid_d;
   logic         ptr_q, ptr_d;
   logic [15:0]  carry_q, carry_d;
   pc_t          carry_pc_q, carry_pc_d;
   logic         carry_valid, carry_valid_d;

   logic [15:0]  hw;
   logic         hw_is_c;
   pc_t          hw_pc;
   instr_entry_t instr;
   pc_t          instr_pc;
   logic         instr_vld;
   logic         is_flt, use_carry, emit_c, emit_w, split;
   logic         eat_word, eat_carry, carry_move;
   logic         instr_fire, fetch_fire, word_done;
   logic         unused_addr;

   assign unused_addr = fetch_addr_i[0];
   assign carry_valid = (state_q == CARRY);
   assign hw          = hw_select(word_q.data, ptr_q);
   assign hw_pc       = word_pc_q + pc_t'({ptr_q, 1'b0});

   rvc_len_detect #(
      .CExtEn (CExtEn)
   ) i_rvc (
      .hw_i            (hw),
      .is_compressed_o (hw_is_c)
   );

   assign is_flt    = word_q.fault;
   assign use_carry = !is_flt && carry_valid;
   assign emit_c    = !is_flt && !carry_valid && hw_is_c;
   assign emit_w    = !is_flt && !carry_valid && !hw_is_c && !ptr_q;
   assign split     = !is_flt && !carry_valid && !hw_is_c && ptr_q;

   always_comb begin
      instr      = '0;
      instr_vld  = 1'b0;
      instr_pc   = hw_pc;
      eat_word   = 1'b0;
      eat_carry  = 1'b0;
      carry_move = 1'b0;
      if (word_valid_q && !flush_i) begin
         unique case (1'b1)
            is_flt: begin
               instr_vld   = 1'b1;
               instr.fault = 1'b1;
               eat_word    = 1'b1;
               eat_carry   = carry_valid;
               if (carry_valid) instr_pc = carry_pc_q;
            end
            use_carry: begin
               instr_vld   = 1'b1;
               instr.instr = {hw, carry_q};
               instr_pc    = carry_pc_q;
               eat_word    = ptr_q;
               eat_carry   = 1'b1;
            end
            emit_c: begin
               instr_vld        = 1'b1;
               instr.instr      = {16'h0000, hw};
               instr.compressed = 1'b1;
               eat_word         = ptr_q;
            end
            emit_w: begin
               instr_vld   = 1'b1;
               instr.instr = word_q.data;
               eat_word    = 1'b1;
            end
            split: carry_move = 1'b1;
            default: ;
         endcase
      end
   end

   assign instr_valid_o      = instr_vld;
   assign instr_o            = instr.instr;
   assign instr_pc_o         = instr_pc;
   assign instr_compressed_o = instr.compressed;
   assign instr_fault_o      = instr.fault;

   // A split upper half frees the word without any output handshake.
   assign instr_fire    = instr_vld && instr_ready_i;
   assign word_done     = carry_move || (instr_fire && eat_word);
   assign fetch_ready_o = !flush_i && (!word_valid_q || word_done);
   assign fetch_fire    = fetch_valid_i && fetch_ready_o;

   always_comb begin
      word_d        = word_q;
      word_pc_d     = word_pc_q;
      word_valid_d  = word_valid_q && !word_done;
      ptr_d         = ptr_q;
      carry_d       = carry_q;
      carry_pc_d    = carry_pc_q;
      carry_valid_d = carry_valid && !(instr_fire && eat_carry);
      if (word_done) begin
         ptr_d = 1'b0;
      end else if (instr_fire) begin
         ptr_d = 1'b1;
      end
      if (carry_move) begin
         carry_d       = hw;
         carry_pc_d    = hw_pc;
         carry_valid_d = 1'b1;
      end
      if (fetch_fire) begin
         word_d.data  = fetch_data_i;
         word_d.fault = fetch_fault_i;
         word_pc_d    = {fetch_addr_i[Xlen-1:2], 2'b00};
         word_valid_d = 1'b1;
         ptr_d        = CExtEn && !carry_valid_d && fetch_addr_i[1];
      end
      if (flush_i) begin
         word_valid_d  = 1'b0;
         carry_valid_d = 1'b0;
         ptr_d         = 1'b0;
      end
      if (carry_valid_d) begin
         state_d = CARRY;
      end else if (word_valid_d) begin
         state_d = WORD;
      end else begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q       <= '0;
         word_pc_q    <= '0;
         word_valid_q <= 1'b0;
         ptr_q        <= 1'b0;
         carry_q      <= '0;
         carry_pc_q   <= '0;
      end else begin
         word_q       <= word_d;
         word_pc_q    <= word_pc_d;
         word_valid_q <= word_valid_d;
         ptr_q        <= ptr_d;
         carry_q      <= carry_d;
         carry_pc_q   <= carry_pc_d;
      end
   end
endmodule
